// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divider floor and stop-bit
// encodings, kept here so uart_tx can reuse them.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP1,
    ST_STOP2
  } uart_state_e;

  localparam logic [31:0] UART_MIN_DIVIDER = 32'd4;
  localparam logic [1:0]  UART_NSTOP_1     = 2'b00;
  localparam logic [1:0]  UART_NSTOP_2     = 2'b01;

  // Shorter bit periods leave no room for a mid-bit sample point.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < UART_MIN_DIVIDER) ? UART_MIN_DIVIDER : d;
  endfunction

endpackage

// File: rtl/uart_sync2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_sync2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 or 2 stop bits, mid-bit sampling,
// single-entry output holding register with overrun and framing-error pulses.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [31:0] divider_i,
  input  logic [1:0]  nstop_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        frame_err_o,
  output logic        overrun_o
);

  logic rx_s;

  uart_sync2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic        nstop2_q, nstop2_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        rx_prev_q, rx_prev_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        expire;
  logic        deliver;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    nstop2_d  = nstop2_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    rx_prev_d = rx_s;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver   = 1'b0;
    expire    = (cnt_q == 32'd1);

    // Counter stops at 1; every expiry below reloads it explicitly.
    if (state_q != ST_IDLE && !expire)
      cnt_d = cnt_q - 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          div_d    = clamp_div(divider_i);
          nstop2_d = (nstop_i != UART_NSTOP_1);
          cnt_d    = clamp_div(divider_i) >> 1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (expire) begin
          if (!rx_s) begin
            cnt_d   = div_q;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = div_q;
          if (bit_q == 3'd7)
            state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (expire) begin
          if (rx_s) deliver = 1'b1;
          else      ferr_d  = 1'b1;
          cnt_d   = div_q;
          state_d = nstop2_q ? ST_STOP2 : ST_IDLE;
        end
      end
      ST_STOP2: begin
        if (expire)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte consumed in the same cycle frees the slot for the new one.
    if (deliver && (!valid_q || rx_ready_i)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      div_q     <= 32'd0;
      nstop2_q  <= 1'b0;
      shift_q   <= 8'h00;
      bit_q     <= 3'd0;
      rx_prev_q <= 1'b1;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      nstop2_q  <= nstop2_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      rx_prev_q <= rx_prev_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// scored against expectations derived from the serial-frame rules.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic [31:0] divider_i = 32'd16;
  logic [1:0]  nstop_i = 2'b00;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b1;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .divider_i   (divider_i),
    .nstop_i     (nstop_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: consumed bytes, valid rise times, pulse counts, data stability.
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         fe_cnt = 0, ov_cnt = 0, vld_cycles = 0, unstable = 0;
  logic       vld_d1 = 1'b0;
  logic [7:0] data_d1 = 8'h00;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rx_valid_o && !vld_d1) rise_q.push_back(cyc);
      if (rx_valid_o) vld_cycles <= vld_cycles + 1;
      if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      if (frame_err_o) fe_cnt <= fe_cnt + 1;
      if (overrun_o) ov_cnt <= ov_cnt + 1;
      if (rx_valid_o && vld_d1 && rx_data_o != data_d1) unstable <= unstable + 1;
    end
    vld_d1  <= rx_valid_o;
    data_d1 <= rx_data_o;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int t_start;
  int g0, f0, o0, v0;

  task automatic snap();
    g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; v0 = vld_cycles;
  endtask

  // d is the bit period the line really uses (after clamping).
  task automatic send_frame(input logic [7:0] b, input int d, input int nb,
                            input logic stop1, input logic stop2, input int gap);
    @(posedge clk_i); #1;
    t_start = cyc;
    rx_i = 1'b0;
    repeat (d) @(posedge clk_i); #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (d) @(posedge clk_i); #1;
    end
    rx_i = stop1;
    repeat (d) @(posedge clk_i); #1;
    if (nb == 2) begin
      rx_i = stop2;
      repeat (d) @(posedge clk_i); #1;
    end
    rx_i = 1'b1;
    repeat (gap) @(posedge clk_i);
  endtask

  // Spec latency is 9.5*D+3 within one cycle; compare doubled to stay integral.
  function automatic logic lat_ok(input int lat, input int d);
    int e2;
    e2 = 2 * lat - (19 * d + 6);
    return (e2 >= -2 && e2 <= 2);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 8'h00);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // 0x55 at divider 868, 1 stop bit
    divider_i = 32'd868; nstop_i = 2'b00; rx_ready_i = 1'b1;
    snap();
    send_frame(8'h55, 868, 1, 1'b1, 1'b1, 20);
    chk("b55_cnt", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("b55_data", got_q[g0], 8'h55);
    lat = (rise_q.size() > 0) ? rise_q[$] - t_start : -1;
    chk($sformatf("b55_lat lat=%0d want 8249+-1", lat), (lat >= 8248 && lat <= 8250), 1);
    chk("b55_ferr", fe_cnt - f0, 0);
    chk("b55_ovr", ov_cnt - o0, 0);

    // Back-to-back 0x5A, 0xA5
    divider_i = 32'd16;
    snap();
    send_frame(8'h5A, 16, 1, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 16, 1, 1'b1, 1'b1, 20);
    chk("b2b_cnt", got_q.size() - g0, 2);
    chk("b2b_vcyc", vld_cycles - v0, 2);
    if (got_q.size() >= g0 + 2) begin
      chk("b2b_d0", got_q[g0], 8'h5A);
      chk("b2b_d1", got_q[g0+1], 8'hA5);
    end
    chk("b2b_ovr", ov_cnt - o0, 0);

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready_i = 1'b0;
    snap();
    send_frame(8'h11, 16, 1, 1'b1, 1'b1, 8);
    send_frame(8'h22, 16, 1, 1'b1, 1'b1, 8);
    #1;
    chk("ovr_pulses", ov_cnt - o0, 1);
    chk("ovr_valid", rx_valid_o, 1);
    chk("ovr_data", rx_data_o, 8'h11);
    chk("ovr_stable", unstable, 0);
    @(posedge clk_i); #1;
    rx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ovr_vclr", rx_valid_o, 0);
    chk("ovr_cnt", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("ovr_got", got_q[g0], 8'h11);

    // Framing error on 0xFF, then good 0x3C
    snap();
    send_frame(8'hFF, 16, 1, 1'b0, 1'b1, 10);
    chk("fe_pulses", fe_cnt - f0, 1);
    chk("fe_novalid", vld_cycles - v0, 0);
    send_frame(8'h3C, 16, 1, 1'b1, 1'b1, 20);
    chk("fe_next_cnt", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("fe_next_data", got_q[g0], 8'h3C);

    // 200-cycle glitch at divider 868, then a short frame proves IDLE
    divider_i = 32'd868;
    snap();
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    repeat (200) @(posedge clk_i); #1;
    rx_i = 1'b1;
    repeat (600) @(posedge clk_i);
    chk("gl_valid", vld_cycles - v0, 0);
    chk("gl_ferr", fe_cnt - f0, 0);
    chk("gl_ovr", ov_cnt - o0, 0);
    divider_i = 32'd8;
    send_frame(8'h96, 8, 1, 1'b1, 1'b1, 20);
    chk("gl_next_cnt", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("gl_next_data", got_q[g0], 8'h96);

    // Reset in mid-DATA (line high while reset), then 0xC3 with divider changed mid-frame
    divider_i = 32'd16;
    snap();
    fork
      send_frame(8'hF0, 16, 1, 1'b1, 1'b1, 20);
      begin
        repeat (90) @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (10) @(posedge clk_i); #1;
        chk("mid_rst_data", rx_data_o, 8'h00);
        chk("mid_rst_valid", rx_valid_o, 0);
        rst_i = 1'b0;
      end
    join
    chk("mid_rst_lost", got_q.size() - g0, 0);
    fork
      send_frame(8'hC3, 16, 1, 1'b1, 1'b1, 20);
      begin
        repeat (40) @(posedge clk_i); #1;
        divider_i = 32'd40;
      end
    join
    chk("c3_cnt", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("c3_data", got_q[g0], 8'hC3);
    chk("c3_ferr", fe_cnt - f0, 0);

    // Randomized frames: divider (incl. below floor), stop count, bad stops
    for (int n = 0; n < 16; n++) begin
      int div, d, nb, gap;
      logic [7:0] b;
      logic s1, s2;
      div = $urandom_range(0, 24);
      d   = (div < 4) ? 4 : div;
      divider_i = div;
      nstop_i = 2'($urandom_range(0, 3));
      nb  = (nstop_i == 2'b00) ? 1 : 2;
      b   = 8'($urandom);
      s1  = ($urandom_range(0, 4) != 0);
      s2  = 1'($urandom_range(0, 1));
      gap = $urandom_range(4, 2 * d + 4);
      snap();
      send_frame(b, d, nb, s1, s2, gap);
      if (s1) begin
        chk($sformatf("rnd%0d_cnt", n), got_q.size() - g0, 1);
        if (got_q.size() > g0) chk($sformatf("rnd%0d_data", n), got_q[g0], b);
        lat = (rise_q.size() > 0) ? rise_q[$] - t_start : -1;
        chk($sformatf("rnd%0d_lat lat=%0d d=%0d", n, lat, d), lat_ok(lat, d), 1);
        chk($sformatf("rnd%0d_ferr", n), fe_cnt - f0, 0);
      end else begin
        chk($sformatf("rnd%0d_cnt", n), got_q.size() - g0, 0);
        chk($sformatf("rnd%0d_ferr", n), fe_cnt - f0, 1);
      end
      chk($sformatf("rnd%0d_ovr", n), ov_cnt - o0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
